// File: rtl/bool_sweep_pkg.sv
// Shared types and helpers for the exhaustive Boolean-function sweeper.
package bool_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Number of vectors in one sweep of an n-input function.
    function automatic int unsigned sweep_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/bool_sweep_lut.sv
// Expected truth table: 2^N_IN x 1 register array, one write port, async read.
module bool_sweep_lut
    import bool_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 4
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [N_IN-1:0] waddr_i,
    input  logic            wdata_i,
    input  logic [N_IN-1:0] raddr_i,
    output logic            rdata_o
);

    localparam int unsigned DEPTH = sweep_len(N_IN);

    // Contents are deliberately not reset; they are don't-care until written.
    logic [DEPTH-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bool_sweep_checker.sv
// Drives every input vector onto a function under test, holds each for SETTLE
// cycles, compares against the programmed truth table and tallies mismatches.
module bool_sweep_checker
    import bool_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [N_IN-1:0] cfg_addr,
    input  logic            cfg_data,
    input  logic            start,
    output logic [N_IN-1:0] sweep_in,
    input  logic            dut_f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state_q;
    logic [N_IN-1:0] idx_q;
    logic [SW-1:0]   settle_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_q;
    logic [N_IN:0]   err_d;
    logic            fev_q;
    logic [N_IN-1:0] fei_q;

    logic            exp_bit;
    logic            sample;
    logic            mismatch;

    bool_sweep_lut #(
        .N_IN (N_IN)
    ) u_lut (
        .clk_i   (clk),
        .we_i    (cfg_we && !busy_q),
        .waddr_i (cfg_addr),
        .wdata_i (cfg_data),
        .raddr_i (idx_q),
        .rdata_o (exp_bit)
    );

    always_comb begin
        sample   = (state_q == RUN) && (settle_q == SW'(SETTLE - 1));
        mismatch = sample && (dut_f != exp_bit);
        err_d    = err_q + {{N_IN{1'b0}}, mismatch};
    end

    // idx_q doubles as the registered sweep vector; it is parked at 0 outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fei_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        idx_q    <= '0;
                        settle_q <= '0;
                        err_q    <= '0;
                        fev_q    <= 1'b0;
                        fei_q    <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (sample) begin
                        err_q <= err_d;
                        if (mismatch && !fev_q) begin
                            fev_q <= 1'b1;
                            fei_q <= idx_q;
                        end
                        if (idx_q == '1) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                            idx_q   <= '0;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            settle_q <= '0;
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sweep_in        = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed bench: a 4-input/SETTLE=2 sweeper against F=(A&B)|(~C&D) and a
// 3-input/SETTLE=1 sweeper against 3-input parity.
module tb_bool_sweep_checker;

    // F=(A&B)|(~C&D), A=bit3: true at 1,5,9,12,13,14,15
    localparam logic [15:0] TT_F = 16'hF222;
    // A^B^C: true at 1,2,4,7
    localparam logic [7:0]  TT_P = 8'h96;

    logic clk;
    logic rst;

    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic       cfg_data;
    logic       start;
    logic [3:0] sweep_in;
    logic       dut_f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_err_valid;
    logic [3:0] first_err_idx;

    logic       cfg_we3;
    logic [2:0] cfg_addr3;
    logic       cfg_data3;
    logic       start3;
    logic [2:0] sweep_in3;
    logic       dut_f3;
    logic       busy3;
    logic       done3;
    logic       pass3;
    logic [3:0] err_count3;
    logic       first_err_valid3;
    logic [2:0] first_err_idx3;

    logic [15:0] tt_model;
    logic        inv_f;
    logic        fault_en;
    logic [3:0]  fault_idx;

    int checks;
    int failures;

    assign dut_f  = tt_model[sweep_in] ^ inv_f ^ (fault_en && (sweep_in == fault_idx));
    assign dut_f3 = TT_P[sweep_in3];

    bool_sweep_checker #(
        .N_IN   (4),
        .SETTLE (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .start           (start),
        .sweep_in        (sweep_in),
        .dut_f           (dut_f),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx)
    );

    bool_sweep_checker #(
        .N_IN   (3),
        .SETTLE (1)
    ) dut3 (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we3),
        .cfg_addr        (cfg_addr3),
        .cfg_data        (cfg_data3),
        .start           (start3),
        .sweep_in        (sweep_in3),
        .dut_f           (dut_f3),
        .busy            (busy3),
        .done            (done3),
        .pass            (pass3),
        .err_count       (err_count3),
        .first_err_valid (first_err_valid3),
        .first_err_idx   (first_err_idx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic program_tt(input logic [15:0] tt);
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = tt[i];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulses start, then counts busy cycles until done (or reset/timeout).
    task automatic run_sweep(input int disturb_at, input int rst_at,
                             output int busy_cycles, output int done_cnt);
        busy_cycles = 0;
        done_cnt    = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start  = 1'b0;
            cfg_we = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                break;
            end
            if (busy_cycles == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (busy_cycles == disturb_at) begin
                start    = 1'b1;
                cfg_we   = 1'b1;
                cfg_addr = 4'd3;
                cfg_data = ~TT_F[3];
            end
        end
    endtask

    task automatic check_result(input string tag, input int bc, input int dc,
                                input int exp_bc, input int exp_err, input logic exp_pass,
                                input logic exp_fev, input int exp_fei);
        check({tag, "_busy_cycles"}, bc, exp_bc);
        check({tag, "_done_seen"}, dc, 1);
        check({tag, "_err_count"}, err_count, exp_err);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_first_err_valid"}, first_err_valid, exp_fev);
        if (exp_fev) check({tag, "_first_err_idx"}, first_err_idx, exp_fei);
        check({tag, "_sweep_in_fin"}, sweep_in, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_pass_held"}, pass, exp_pass);
    endtask

    initial begin
        int bc;
        int dc;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = 1'b0;
        start     = 1'b0;
        cfg_we3   = 1'b0;
        cfg_addr3 = '0;
        cfg_data3 = 1'b0;
        start3    = 1'b0;
        tt_model  = TT_F;
        inv_f     = 1'b0;
        fault_en  = 1'b0;
        fault_idx = 4'd5;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err_valid", first_err_valid, 0);
        check("rst_first_err_idx", first_err_idx, 0);
        check("rst_sweep_in", sweep_in, 0);
        check("rst3_busy", busy3, 0);
        check("rst3_sweep_in", sweep_in3, 0);
        rst = 1'b0;

        program_tt(TT_F);

        run_sweep(-1, -1, bc, dc);
        check_result("match", bc, dc, 32, 0, 1'b1, 1'b0, 0);

        fault_en = 1'b1;
        run_sweep(-1, -1, bc, dc);
        check_result("fault5", bc, dc, 32, 1, 1'b0, 1'b1, 5);
        fault_en = 1'b0;

        inv_f = 1'b1;
        run_sweep(-1, -1, bc, dc);
        check_result("inverted", bc, dc, 32, 16, 1'b0, 1'b1, 0);

        program_tt(~TT_F);
        run_sweep(-1, -1, bc, dc);
        check_result("reprog_inv", bc, dc, 32, 0, 1'b1, 1'b0, 0);

        // Abort a failing sweep with reset partway through.
        program_tt(TT_F);
        run_sweep(-1, 10, bc, dc);
        check("midrst_busy", busy, 0);
        check("midrst_sweep_in", sweep_in, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_first_err_valid", first_err_valid, 0);
        check("midrst_done", dc, 0);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("midrst_no_done_later", dc, 0);
        inv_f = 1'b0;
        run_sweep(-1, -1, bc, dc);
        check_result("after_rst", bc, dc, 32, 0, 1'b1, 1'b0, 0);

        // start and a table write arrive mid-sweep and must both be ignored.
        run_sweep(5, -1, bc, dc);
        check_result("disturbed", bc, dc, 32, 0, 1'b1, 1'b0, 0);
        run_sweep(-1, -1, bc, dc);
        check_result("table3_kept", bc, dc, 32, 0, 1'b1, 1'b0, 0);

        // 3-input, single-cycle settle instance.
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we3   = 1'b1;
            cfg_addr3 = 3'(i);
            cfg_data3 = TT_P[i];
        end
        @(negedge clk);
        cfg_we3 = 1'b0;
        start3  = 1'b1;
        bc = 0;
        dc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (busy3) begin
                check("s1_sweep_in_step", sweep_in3, bc);
                bc++;
            end
            if (done3) begin
                dc++;
                break;
            end
        end
        check("s1_busy_cycles", bc, 8);
        check("s1_done_seen", dc, 1);
        check("s1_pass", pass3, 1);
        check("s1_err_count", err_count3, 0);
        check("s1_sweep_in_fin", sweep_in3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
